// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared types for the branch target buffer
// Purpose: PC type, table entry struct, sweep FSM state enum and the
//          2-bit saturating counter step function.
// Ports:   none (package).
package branch_target_buffer_pkg;

  localparam int unsigned PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;
  typedef logic [1:0]      ctr_t;

  // The tag field is PC-wide; a stored tag is zero-extended into it so the
  // struct stays independent of the table depth.
  typedef struct packed {
    logic valid;
    pc_t  tag;
    pc_t  target;
    ctr_t ctr;
  } BTBEntry;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_SWEEP = 1'b1
  } BTBState;

  // 00 strong NT, 01 weak NT, 10 weak T, 11 strong T; saturates at both ends.
  function automatic ctr_t btbCtrNext(input ctr_t ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    end
    return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup, execute training and invalidate bundle
// Purpose: groups the BTB lookup, training and invalidation signals.
// Ports (master drives / slave drives):
//   pc, updateValid, updatePc, updateTaken, updateTarget, invalidateReq : master
//   btbHit, btbPredictedPc, invalidateBusy                              : slave
interface branch_target_buffer_if #(
  parameter int unsigned PC_WIDTH = 32
);

  logic [PC_WIDTH-1:0] pc;
  logic                btbHit;
  logic [PC_WIDTH-1:0] btbPredictedPc;
  logic                updateValid;
  logic [PC_WIDTH-1:0] updatePc;
  logic                updateTaken;
  logic [PC_WIDTH-1:0] updateTarget;
  logic                invalidateReq;
  logic                invalidateBusy;

  modport master (
    output pc, updateValid, updatePc, updateTaken, updateTarget, invalidateReq,
    input  btbHit, btbPredictedPc, invalidateBusy
  );

  modport slave (
    input  pc, updateValid, updatePc, updateTaken, updateTarget, invalidateReq,
    output btbHit, btbPredictedPc, invalidateBusy
  );

endinterface

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped branch target buffer with sweep invalidation
// Purpose: same-cycle lookup of the fetch PC against a flop table of
//          tag/target/2-bit counter, trained by resolved branches, with a
//          one-entry-per-cycle bulk invalidate sweep.
// Ports:
//   clk  in  single clock, all state updates on posedge
//   rst  in  asynchronous active-low reset
//   btb  slave modport of branch_target_buffer_if (lookup, training, invalidate)
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 16,
  parameter int unsigned PC_WIDTH  = PC_W
) (
  input logic                  clk,
  input logic                  rst,
  branch_target_buffer_if.slave btb
);

  localparam int unsigned INDEX_W = $clog2(ENTRY_NUM);
  localparam int unsigned TAG_W   = PC_WIDTH - INDEX_W - 2;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRY_NUM - 1);

  // Table storage: valid/ctr are reset, tag/target are not.
  logic                valid_q  [ENTRY_NUM];
  ctr_t                ctr_q    [ENTRY_NUM];
  logic [TAG_W-1:0]    tag_q    [ENTRY_NUM];
  logic [PC_WIDTH-1:0] target_q [ENTRY_NUM];

  BTBState             state_q, state_d;
  logic [INDEX_W-1:0]  sweep_idx_q, sweep_idx_d;
  logic                busy;

  // ---------------- lookup ----------------
  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  BTBEntry            lk_entry;
  logic               lk_hit;

  assign lk_idx = btb.pc[INDEX_W+1:2];
  assign lk_tag = btb.pc[PC_WIDTH-1:INDEX_W+2];

  always_comb begin
    lk_entry        = '0;
    lk_entry.valid  = valid_q[lk_idx];
    lk_entry.tag    = PC_W'(tag_q[lk_idx]);
    lk_entry.target = PC_W'(target_q[lk_idx]);
    lk_entry.ctr    = ctr_q[lk_idx];
  end

  // Reads registered state only: an update in this cycle shows up next cycle.
  assign lk_hit = lk_entry.valid && (lk_entry.tag == PC_W'(lk_tag)) &&
                  lk_entry.ctr[1] && !busy;

  assign btb.btbHit         = lk_hit;
  assign btb.btbPredictedPc = lk_hit ? PC_WIDTH'(lk_entry.target) : '0;

  // ---------------- training ----------------
  logic [INDEX_W-1:0] u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic               upd_en;
  logic               upd_hit;
  ctr_t               upd_ctr_d;

  assign u_idx     = btb.updatePc[INDEX_W+1:2];
  assign u_tag     = btb.updatePc[PC_WIDTH-1:INDEX_W+2];
  // The request cycle and the whole sweep drop training; no retry exists.
  assign upd_en    = btb.updateValid && !busy && !btb.invalidateReq;
  assign upd_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_ctr_d = btbCtrNext(ctr_q[u_idx], btb.updateTaken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ENTRY_NUM); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else if (busy) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (upd_en) begin
      if (upd_hit) begin
        ctr_q[u_idx] <= upd_ctr_d;
      end else if (btb.updateTaken) begin
        valid_q[u_idx] <= 1'b1;
        ctr_q[u_idx]   <= 2'b10;
      end
    end
  end

  // On a hit the tag rewrite is a no-op, so any taken update writes both.
  always_ff @(posedge clk) begin
    if (upd_en && btb.updateTaken) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= btb.updateTarget;
    end
  end

  // ---------------- invalidate sweep FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BTB_IDLE;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (btb.invalidateReq) begin
      // A request mid-sweep restarts from entry 0.
      state_d     = BTB_SWEEP;
      sweep_idx_d = '0;
    end else if (state_q == BTB_SWEEP) begin
      if (sweep_idx_q == LAST_IDX) begin
        state_d = BTB_IDLE;
      end
      sweep_idx_d = sweep_idx_q + 1'b1;
    end
  end

  always_comb begin
    busy = (state_q == BTB_SWEEP);
  end

  assign btb.invalidateBusy = busy;

  logic unused_bits;
  assign unused_bits = ^{btb.pc[1:0], btb.updatePc[1:0], lk_entry.ctr[0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  branch_target_buffer_if #(.PC_WIDTH(32)) bif ();

  branch_target_buffer #(.ENTRY_NUM(16), .PC_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .btb (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bif.updateValid  = 1'b1;
    bif.updatePc     = pc;
    bif.updateTaken  = taken;
    bif.updateTarget = tgt;
    tick();
    bif.updateValid  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic [31:0] tgt);
    bif.pc = pc;
    #1;
    check({tag, "_hit"}, {31'd0, bif.btbHit}, {31'd0, hit});
    check({tag, "_pc"}, bif.btbPredictedPc, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.pc            = 32'h100;
    bif.updateValid   = 1'b0;
    bif.updatePc      = '0;
    bif.updateTaken   = 1'b0;
    bif.updateTarget  = '0;
    bif.invalidateReq = 1'b0;

    // 1. reset state
    tick();
    tick();
    look("reset", 32'h100, 1'b0, 32'h0);
    check("reset_busy", {31'd0, bif.invalidateBusy}, 32'd0);
    rst = 1'b1;
    tick();
    look("post_reset", 32'h100, 1'b0, 32'h0);

    // 2. allocate, hit, same-index tag miss
    upd(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 1'b1, 32'h200);
    look("tag_diff", 32'h140, 1'b0, 32'h0);
    look("pc_lsbs_ignored", 32'h103, 1'b1, 32'h200);

    // 3. counter walk 10 -> 01 -> 00 -> 01 -> 10
    upd(32'h100, 1'b0, 32'h0);
    look("ctr01", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    look("ctr00_sat", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h300);
    look("ctr01_up", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h304);
    look("ctr10_up", 32'h100, 1'b1, 32'h304);
    upd(32'h140, 1'b0, 32'h0);
    look("nt_miss_nochange", 32'h100, 1'b1, 32'h304);

    // 4. fill all entries, sweep, all miss afterwards
    for (int i = 0; i < 16; i++) upd(32'h1000 + 32'(i * 4), 1'b1, 32'h8000 + 32'(i * 4));
    look("fill0", 32'h1000, 1'b1, 32'h8000);
    look("fill5", 32'h1014, 1'b1, 32'h8014);
    look("fill15", 32'h103C, 1'b1, 32'h803C);
    look("replaced_idx0", 32'h100, 1'b0, 32'h0);
    bif.invalidateReq = 1'b1;
    look("req_cycle", 32'h1000, 1'b1, 32'h8000);
    check("req_cycle_busy", {31'd0, bif.invalidateBusy}, 32'd0);
    tick();
    bif.invalidateReq = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bif.pc = 32'h103C;
      #1;
      check($sformatf("sweep1_busy%0d", k), {31'd0, bif.invalidateBusy}, 32'd1);
      check($sformatf("sweep1_hit%0d", k), {31'd0, bif.btbHit}, 32'd0);
      tick();
    end
    check("sweep1_done", {31'd0, bif.invalidateBusy}, 32'd0);
    for (int i = 0; i < 16; i++)
      look($sformatf("after_sweep%0d", i), 32'h1000 + 32'(i * 4), 1'b0, 32'h0);

    // 5. updates on request cycle / during sweep dropped; re-pulse restarts
    bif.invalidateReq = 1'b1;
    upd(32'h2000, 1'b1, 32'hA000);
    bif.invalidateReq = 1'b0;
    repeat (4) tick();
    upd(32'h2004, 1'b1, 32'hA004);
    repeat (2) tick();
    check("sweep2_mid_busy", {31'd0, bif.invalidateBusy}, 32'd1);
    bif.invalidateReq = 1'b1;
    tick();
    bif.invalidateReq = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("repulse_busy%0d", k), {31'd0, bif.invalidateBusy}, 32'd1);
      if (k >= 14) begin
        upd(32'h3000 + 32'((k - 14) * 4), 1'b1, 32'hB000);
      end else begin
        tick();
      end
    end
    check("repulse_done", {31'd0, bif.invalidateBusy}, 32'd0);
    look("drop_req_cycle", 32'h2000, 1'b0, 32'h0);
    look("drop_sweep", 32'h2004, 1'b0, 32'h0);
    look("drop_late0", 32'h3000, 1'b0, 32'h0);
    look("drop_late1", 32'h3004, 1'b0, 32'h0);

    // 6. no bypass on same-cycle lookup+update
    upd(32'h100, 1'b1, 32'h200);
    bif.pc           = 32'h100;
    bif.updateValid  = 1'b1;
    bif.updatePc     = 32'h100;
    bif.updateTaken  = 1'b1;
    bif.updateTarget = 32'h400;
    #1;
    check("bypass_old_hit", {31'd0, bif.btbHit}, 32'd1);
    check("bypass_old_pc", bif.btbPredictedPc, 32'h200);
    tick();
    bif.updateValid = 1'b0;
    look("bypass_new", 32'h100, 1'b1, 32'h400);

    // async reset mid-sweep
    bif.invalidateReq = 1'b1;
    tick();
    bif.invalidateReq = 1'b0;
    repeat (3) tick();
    check("pre_rst_busy", {31'd0, bif.invalidateBusy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bif.invalidateBusy}, 32'd0);
    check("async_rst_hit", {31'd0, bif.btbHit}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("rst_released_busy", {31'd0, bif.invalidateBusy}, 32'd0);
    look("rst_released", 32'h100, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
